fft_2d_corner_turn: RTL and testbench
=====================================

FFT_2D_CORNER_TURN -- requirements
Module: fft_2d_corner_turn

Interface
REQ-001 Parameter N, default 4: transform size; legal values 4, 8, 16; any other value SHALL cause an elaboration-time fatal error.
REQ-002 Parameter DATA_W, default 16: width of each real and imaginary component.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 mode  input  1  0 = transpose (column-major output), 1 = pass-through (row-major output); sampled per frame.
REQ-006 flush  input  1  synchronous discard of the partially written frame.
REQ-007 in_valid  input  1  in_data holds one valid row.
REQ-008 in_ready  output  1  block accepts a row this cycle.
REQ-009 in_data  input  N*2*DATA_W  one row; element k SHALL occupy bits [(k+1)*2*DATA_W-1 : k*2*DATA_W], with real in the upper DATA_W bits and imaginary in the lower.
REQ-010 out_valid  output  1  out_data holds one valid output vector.
REQ-011 out_ready  input  1  downstream accepts the vector this cycle.
REQ-012 out_data  output  N*2*DATA_W  one column (transpose) or one row (pass); packing SHALL match in_data.
REQ-013 out_last  output  1  high with the final (N-th) vector of a frame.

Function
REQ-014 Storage SHALL be two ping-pong banks, each holding N x N complex words, plus per-bank full flag and latched mode bit.
REQ-015 A row handshake (in_valid & in_ready) SHALL write in_data into row wr_row of bank wb, then increment wr_row (0..N-1).
REQ-016 On the handshake with wr_row = 0, the block SHALL latch mode into bank wb's mode bit; mode changes mid-frame SHALL have no effect.
REQ-017 On the handshake with wr_row = N-1, the block SHALL set full[wb], toggle wb, and clear wr_row to 0.
REQ-018 in_ready SHALL equal !full[wb].
REQ-019 out_valid SHALL equal full[rb]; it SHALL first assert the cycle after the row N-1 handshake, giving 1-cycle fill-to-output latency.
REQ-020 In transpose mode, out_data element k SHALL equal bank rb row k, element rd_col; in pass mode it SHALL equal bank rb row rd_col.
REQ-021 An output handshake (out_valid & out_ready) SHALL increment rd_col (0..N-1); at rd_col = N-1 the block SHALL clear full[rb], toggle rb, and clear rd_col.
REQ-022 out_last SHALL equal out_valid & (rd_col = N-1).
REQ-023 While out_valid & !out_ready, out_data, out_last and out_valid SHALL hold stable.
REQ-024 Writing bank wb and reading bank rb in the same cycle SHALL both proceed, sustaining one frame per N cycles with no bubbles when both sides are always ready.
REQ-025 When both banks are full, in_ready SHALL be 0 and no write SHALL occur.
REQ-026 If full[rb] is cleared and full[wb] is set in the same cycle on the same bank index, both updates SHALL take effect.
REQ-027 flush SHALL clear wr_row to 0 and discard the in-progress frame; a row handshake in the same cycle SHALL be ignored.
REQ-028 flush SHALL NOT affect full banks, rd_col, rb or the output stream.
REQ-029 Data SHALL pass through unmodified: no arithmetic, scaling or rounding.

Reset
REQ-030 Asserting reset SHALL immediately set full[1:0]=0, wb=0, rb=0, wr_row=0, rd_col=0 and the mode bits to 0, giving out_valid=0, out_last=0, in_ready=1.
REQ-031 Bank contents SHALL NOT be reset; out_data is don't-care while out_valid=0.
REQ-032 Reset mid-frame SHALL discard all partial and full frames; the first frame after release SHALL start at row 0.

Verification
REQ-033 Transpose (N=4): write elements re=4r+c, im=0; out_ready=1 -> one cycle after the last row, 4 vectors: vector c, element k = 4k+c; out_last on the 4th.
REQ-034 Pass mode: same stimulus with mode=1 -> vector r element k = 4r+k; a mode toggle at row 2 does not change the frame.
REQ-035 Back-pressure: out_ready=0, stream 3 frames -> in_ready drops after frame 2; frame 3 is accepted only after frame 1's last column handshake; no data loss or reordering.
REQ-036 Continuous streaming: in_valid=out_ready=1 for 5 frames -> output is gap-free at 4 vectors per frame, with out_last every 4th cycle.
REQ-037 flush after 2 rows, then a full frame -> only the full frame is output.
REQ-038 Reset asserted while one bank is full and one is half-written -> out_valid=0 immediately; after release, a new frame is output correctly from bank 0.

Source files
------------

// File: rtl/fft_2d_corner_turn.sv
// Ping-pong corner-turn buffer for a 2-D FFT: rows in, columns (transpose) or rows (pass) out.
// Two N x N complex banks; one fills while the other drains, one frame per N cycles.
module fft_2d_corner_turn #(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*2*DATA_W-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*2*DATA_W-1:0] out_data,
  output logic                  out_last
);

  localparam int unsigned EW = 2 * DATA_W;
  localparam int unsigned IW = $clog2(N);
  localparam logic [IW-1:0] LastIdx = IW'(N - 1);

  generate
    if (N != 4 && N != 8 && N != 16) begin : g_bad_n
      $fatal(1, "fft_2d_corner_turn: N must be 4, 8 or 16");
    end
  endgenerate

  logic [EW-1:0] mem_q [2][N][N];

  logic [1:0]    full_q, full_d;
  logic [1:0]    mode_q, mode_d;
  logic          wb_q, wb_d;
  logic          rb_q, rb_d;
  logic [IW-1:0] wr_row_q, wr_row_d;
  logic [IW-1:0] rd_col_q, rd_col_d;
  logic          wr_en, rd_en;

  assign in_ready  = ~full_q[wb_q];
  assign out_valid = full_q[rb_q];
  assign out_last  = out_valid & (rd_col_q == LastIdx);
  // A row offered in the flush cycle is dropped along with the partial frame.
  assign wr_en     = in_valid & in_ready & ~flush;
  assign rd_en     = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q   <= '0;
      mode_q   <= '0;
      wb_q     <= 1'b0;
      rb_q     <= 1'b0;
      wr_row_q <= '0;
      rd_col_q <= '0;
    end else begin
      full_q   <= full_d;
      mode_q   <= mode_d;
      wb_q     <= wb_d;
      rb_q     <= rb_d;
      wr_row_q <= wr_row_d;
      rd_col_q <= rd_col_d;
    end
  end

  // Bank storage carries no reset; full flags gate every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < N; k++) begin
        mem_q[wb_q][wr_row_q][k] <= in_data[k*EW +: EW];
      end
    end
  end

  always_comb begin
    full_d   = full_q;
    mode_d   = mode_q;
    wb_d     = wb_q;
    rb_d     = rb_q;
    wr_row_d = wr_row_q;
    rd_col_d = rd_col_q;
    // Read-side clear is applied before write-side set so both land on a shared index.
    if (rd_en) begin
      if (rd_col_q == LastIdx) begin
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
        rd_col_d     = '0;
      end else begin
        rd_col_d = rd_col_q + 1'b1;
      end
    end
    if (flush) begin
      wr_row_d = '0;
    end else if (wr_en) begin
      if (wr_row_q == '0) begin
        mode_d[wb_q] = mode;
      end
      if (wr_row_q == LastIdx) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
        wr_row_d     = '0;
      end else begin
        wr_row_d = wr_row_q + 1'b1;
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < N; k++) begin
      if (mode_q[rb_q]) begin
        out_data[k*EW +: EW] = mem_q[rb_q][rd_col_q][k];
      end else begin
        out_data[k*EW +: EW] = mem_q[rb_q][k][rd_col_q];
      end
    end
  end

endmodule

// File: tb/tb_fft_2d_corner_turn.sv
// Self-checking bench for fft_2d_corner_turn: random frames checked against a matrix model
// that computes each output vector directly from the written N x N frame.
module tb_fft_2d_corner_turn;

  localparam int N      = 4;
  localparam int DATA_W = 16;
  localparam int EW     = 2 * DATA_W;
  localparam int W      = N * EW;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         mode = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_last;

  always #5 clk = ~clk;

  fft_2d_corner_turn #(.N(N), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  typedef logic [EW-1:0] mat_t [N][N];
  typedef struct {
    logic [W-1:0] data;
    logic         last;
    int           cyc;
  } obs_t;

  obs_t         obs_q[$];
  logic [W:0]   exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output handshake; inputs are stable at the falling edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) obs_q.push_back('{data: out_data, last: out_last, cyc: cyc});
  end

  task automatic rand_mat(output mat_t m);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) m[r][c] = $urandom;
  endtask

  function automatic logic [W-1:0] pack_row(input mat_t m, input int r);
    logic [W-1:0] v;
    for (int k = 0; k < N; k++) v[k*EW +: EW] = m[r][k];
    return v;
  endfunction

  // Model: transpose emits column v, pass emits row v; last on the N-th vector.
  function automatic void expect_frame(input mat_t m, input bit pass);
    logic [W-1:0] e;
    for (int v = 0; v < N; v++) begin
      for (int k = 0; k < N; k++) e[k*EW +: EW] = pass ? m[v][k] : m[k][v];
      exp_q.push_back({(v == N - 1), e});
    end
  endfunction

  task automatic drive_row(input logic [W-1:0] d, input logic m, output int acc);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL row_accept_timeout in_ready=%0b required=1", in_ready);
    end
    acc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input mat_t m, input bit pass, output int first_acc);
    int acc;
    for (int r = 0; r < N; r++) begin
      drive_row(pack_row(m, r), pass, acc);
      if (r == 0) first_acc = acc;
    end
  endtask

  task automatic wait_obs(input int n);
    int t = 0;
    while (obs_q.size() < n && t < 300) begin
      @(posedge clk);
      t++;
    end
    #1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%0b want=0", out_last); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_transpose();
    mat_t m;
    int   acc, a0;
    obs_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) m[r][c] = {16'(4 * r + c), 16'h0000};
    expect_frame(m, 1'b0);
    for (int r = 0; r < N; r++) drive_row(pack_row(m, r), 1'b0, acc);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL transpose_latency out_valid=%0b want=1", out_valid); end
    wait_obs(N);
    total++; if (obs_q.size() != N) begin bad++; $display("FAIL transpose_count got=%0d want=%0d", obs_q.size(), N); end
    if (obs_q.size() > 0) begin
      total++;
      if (obs_q[0].cyc != acc + 1) begin bad++; $display("FAIL transpose_first_cycle got=%0d want=%0d", obs_q[0].cyc, acc + 1); end
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if ({obs_q[i].last, obs_q[i].data} !== exp_q[i]) begin
        bad++; $display("FAIL transpose_vec%0d got=%h want=%h", i, {obs_q[i].last, obs_q[i].data}, exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
    rand_mat(m);
    expect_frame(m, 1'b0);
    send_frame(m, 1'b0, a0);
    in_valid = 1'b0;
    wait_obs(N);
    total++; if (obs_q.size() != N) begin bad++; $display("FAIL transpose_rand_count got=%0d want=%0d", obs_q.size(), N); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if ({obs_q[i].last, obs_q[i].data} !== exp_q[i]) begin
        bad++; $display("FAIL transpose_rand_vec%0d got=%h want=%h", i, {obs_q[i].last, obs_q[i].data}, exp_q[i]);
      end
    end
  endtask

  task automatic test_pass();
    mat_t m;
    int   acc;
    obs_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    rand_mat(m);
    expect_frame(m, 1'b1);
    // Mode falls back to transpose from row 2 on; the frame must stay in pass mode.
    for (int r = 0; r < N; r++) drive_row(pack_row(m, r), (r < 2), acc);
    in_valid = 1'b0;
    mode = 1'b0;
    wait_obs(N);
    total++; if (obs_q.size() != N) begin bad++; $display("FAIL pass_count got=%0d want=%0d", obs_q.size(), N); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if ({obs_q[i].last, obs_q[i].data} !== exp_q[i]) begin
        bad++; $display("FAIL pass_vec%0d got=%h want=%h", i, {obs_q[i].last, obs_q[i].data}, exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    mat_t m;
    int   a0;
    obs_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    for (int f = 0; f < 5; f++) begin
      bit p;
      p = $urandom_range(1, 0);
      rand_mat(m);
      expect_frame(m, p);
      send_frame(m, p, a0);
    end
    in_valid = 1'b0;
    wait_obs(5 * N);
    total++; if (obs_q.size() != 5 * N) begin bad++; $display("FAIL stream_count got=%0d want=%0d", obs_q.size(), 5 * N); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if ({obs_q[i].last, obs_q[i].data} !== exp_q[i]) begin
        bad++; $display("FAIL stream_vec%0d got=%h want=%h", i, {obs_q[i].last, obs_q[i].data}, exp_q[i]);
      end
      if (i > 0) begin
        total++;
        if (obs_q[i].cyc != obs_q[i-1].cyc + 1) begin
          bad++; $display("FAIL stream_gap%0d got_cycle=%0d want=%0d", i, obs_q[i].cyc, obs_q[i-1].cyc + 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    mat_t m;
    int   acc3, a;
    obs_q.delete(); exp_q.delete();
    out_ready = 1'b0;
    fork
      begin
        for (int f = 0; f < 3; f++) begin
          bit p;
          p = $urandom_range(1, 0);
          rand_mat(m);
          expect_frame(m, p);
          send_frame(m, p, a);
          if (f == 2) acc3 = a;
        end
        in_valid = 1'b0;
      end
      begin
        repeat (20) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%0b want=0", in_ready); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid got=%0b want=1", out_valid); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL bp_out_last got=%0b want=0", out_last); end
        for (int s = 0; s < 3; s++) begin
          total++;
          if (out_data !== exp_q[0][W-1:0]) begin
            bad++; $display("FAIL bp_stall_data%0d got=%h want=%h", s, out_data, exp_q[0][W-1:0]);
          end
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_obs(3 * N);
    total++; if (obs_q.size() != 3 * N) begin bad++; $display("FAIL bp_count got=%0d want=%0d", obs_q.size(), 3 * N); end
    if (obs_q.size() >= N) begin
      total++;
      if (acc3 <= obs_q[N-1].cyc) begin
        bad++; $display("FAIL bp_frame3_early accept_cycle=%0d want_after=%0d", acc3, obs_q[N-1].cyc);
      end
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if ({obs_q[i].last, obs_q[i].data} !== exp_q[i]) begin
        bad++; $display("FAIL bp_vec%0d got=%h want=%h", i, {obs_q[i].last, obs_q[i].data}, exp_q[i]);
      end
    end
  endtask

  task automatic test_flush();
    mat_t m0, m1;
    int   acc;
    obs_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    rand_mat(m0);
    rand_mat(m1);
    drive_row(pack_row(m0, 0), 1'b0, acc);
    drive_row(pack_row(m0, 1), 1'b0, acc);
    in_data = pack_row(m0, 2);
    flush   = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    expect_frame(m1, 1'b1);
    send_frame(m1, 1'b1, acc);
    in_valid = 1'b0;
    wait_obs(N);
    repeat (10) @(posedge clk);
    #1;
    total++; if (obs_q.size() != N) begin bad++; $display("FAIL flush_count got=%0d want=%0d", obs_q.size(), N); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if ({obs_q[i].last, obs_q[i].data} !== exp_q[i]) begin
        bad++; $display("FAIL flush_vec%0d got=%h want=%h", i, {obs_q[i].last, obs_q[i].data}, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    mat_t m;
    int   acc;
    obs_q.delete(); exp_q.delete();
    out_ready = 1'b0;
    rand_mat(m);
    send_frame(m, 1'b0, acc);
    drive_row(pack_row(m, 0), 1'b1, acc);
    drive_row(pack_row(m, 1), 1'b1, acc);
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_out_valid got=%0b want=1", out_valid); end
    reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_out_valid got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready got=%0b want=1", in_ready); end
    @(posedge clk); #1;
    reset = 1'b1;
    obs_q.delete();
    out_ready = 1'b1;
    rand_mat(m);
    expect_frame(m, 1'b0);
    send_frame(m, 1'b0, acc);
    in_valid = 1'b0;
    wait_obs(N);
    repeat (10) @(posedge clk);
    #1;
    total++; if (obs_q.size() != N) begin bad++; $display("FAIL rst_count got=%0d want=%0d", obs_q.size(), N); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if ({obs_q[i].last, obs_q[i].data} !== exp_q[i]) begin
        bad++; $display("FAIL rst_vec%0d got=%h want=%h", i, {obs_q[i].last, obs_q[i].data}, exp_q[i]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_transpose();
    test_pass();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
